// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction prefetch queue. Issues sequential fetch requests to
//            instruction memory under credit control, buffers the in-order
//            responses with their PC+4, and presents them to decode through a
//            valid/ready handshake. A redirect flushes the buffer and marks
//            every in-flight request as stale so its response is dropped.
// Ports    : clk_i, rst_n_i (async active-low)       - clock / reset
//            start_i                                 - fetch enable
//            imem_req_o/imem_addr_o/imem_rdy_i       - request handshake
//            imem_rvalid_i/imem_rdata_i              - in-order responses
//            id_valid_o/id_instr_o/id_pc4_o/id_ready_i - decode handshake
//            redirect_i/redirect_pc_i                - branch/jump redirect
//            perf_fetched_o/perf_discarded_o/perf_stall_o
//                                  - only when FETCH_QUEUE_PERF_EN is defined
// Options  : FETCH_QUEUE_PERF_EN - adds saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rdy_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            id_valid_o,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc4_o,
  input  logic            id_ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_discarded_o,
  output logic [31:0]     perf_stall_o
`endif
);

  localparam int c_ptr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w  = c_ptr_w + 1;
  // Stale responses can pile up across several redirects while memory is
  // slow, so the discard counter gets headroom beyond one buffer's worth.
  localparam int c_disc_w = c_cnt_w + 4;
  localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_req;

  logic [XLEN-1:0]      r_pc;
  logic [31:0]          r_buf_instr [DEPTH];
  logic [XLEN-1:0]      r_buf_pc4   [DEPTH];
  logic [c_ptr_w-1:0]   r_head;
  logic [c_ptr_w-1:0]   r_tail;
  logic [c_cnt_w-1:0]   r_count;
  // r_outstanding counts live requests only; requests made stale by a
  // redirect are moved into r_discard, so the two never overlap.
  logic [c_cnt_w-1:0]   r_outstanding;
  logic [c_disc_w-1:0]  r_discard;

  logic                 w_credit_ok;
  logic                 w_accept;
  logic                 w_resp_live;
  logic                 w_resp_drop;
  logic                 w_resp_take;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_nonempty;
  logic [XLEN-1:0]      w_out_bytes;
  logic [XLEN-1:0]      w_resp_pc4;
  logic                 w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = ^redirect_pc_i[1:0];

  // --------------------------------------------------------------------------
  // Credit and handshake decode
  // --------------------------------------------------------------------------
  assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_depth;
  assign w_accept    = w_req && imem_rdy_i;
  assign w_nonempty  = (r_count != '0);

  // Responses are in order and stale ones always precede live ones, so a
  // non-zero discard count means the arriving word is stale.
  assign w_resp_drop = imem_rvalid_i && (r_discard != '0);
  assign w_resp_live = imem_rvalid_i && (r_discard == '0) && (r_outstanding != '0);
  assign w_resp_take = w_resp_drop || w_resp_live;

  assign w_push = w_resp_live && !redirect_i;
  assign w_pop  = w_nonempty && id_ready_i && !redirect_i;

  // Live requests are consecutive words ending just below r_pc, so the
  // oldest one (the one answering now) sits at r_pc - 4*outstanding.
  assign w_out_bytes = XLEN'(r_outstanding) << 2;
  assign w_resp_pc4  = r_pc - w_out_bytes + XLEN'(4);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_req = !redirect_i && w_credit_ok;
        if (!start_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PC, credit counters and buffer pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
    end else if (redirect_i) begin
      r_pc          <= {redirect_pc_i[XLEN-1:2], 2'b00};
      r_outstanding <= '0;
      // Everything still in flight after this cycle's response becomes stale.
      r_discard     <= r_discard + c_disc_w'(r_outstanding) - c_disc_w'(w_resp_take);
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
    end else begin
      if (w_accept) begin
        r_pc <= r_pc + XLEN'(4);
      end
      r_outstanding <= r_outstanding + c_cnt_w'(w_accept) - c_cnt_w'(w_resp_live);
      r_discard     <= r_discard - c_disc_w'(w_resp_drop);
      r_count       <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
    end
  end

  // Buffer storage needs no reset: an entry is only visible once counted.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_buf_instr[r_tail] <= imem_rdata_i;
      r_buf_pc4[r_tail]   <= w_resp_pc4;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;
  assign id_valid_o  = w_nonempty;
  // Gate the head entry so uninitialised storage never shows while empty.
  assign id_instr_o  = w_nonempty ? r_buf_instr[r_head] : '0;
  assign id_pc4_o    = w_nonempty ? r_buf_pc4[r_head]   : '0;

`ifdef FETCH_QUEUE_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_discarded;
  logic [31:0] r_perf_stall;
  logic        w_dropped;
  logic        w_stall;

  // A live word arriving with a redirect is dropped as well.
  assign w_dropped = w_resp_take && !w_push;
  assign w_stall   = (r_state == RUN) && !w_req;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_perf_fetched   <= '0;
      r_perf_discarded <= '0;
      r_perf_stall     <= '0;
    end else begin
      if (w_push && (r_perf_fetched != '1)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_dropped && (r_perf_discarded != '1)) begin
        r_perf_discarded <= r_perf_discarded + 32'd1;
      end
      if (w_stall && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched_o   = r_perf_fetched;
  assign perf_discarded_o = r_perf_discarded;
  assign perf_stall_o     = r_perf_stall;
`else
  // Counters absent in this build.
`endif

endmodule
`default_nettype wire
